snn_upsample2d: RTL and testbench
=================================

Name: snn_upsample2d

Overview:
- Spike-domain 2D nearest-neighbour upsampling (unpooling) layer, the decoder-side inverse of the spike max-pooling stage.
- Each accepted input spike at (ch, y, x) is expanded into SCALE×SCALE output spikes covering (y*SCALE+dy, x*SCALE+dx).
- Sits between a pooled feature stream and a higher-resolution conv/deconv layer.
- Input and output use the accelerator's 48-bit spike AXI-Stream format.

Parameters:
- INPUT_WIDTH, 14, input feature map width.
- INPUT_HEIGHT, 14, input feature map height.
- INPUT_CHANNELS, 32, number of channels (max 256).
- SCALE, 2, upsampling factor per axis (2..4). INPUT_WIDTH*SCALE and INPUT_HEIGHT*SCALE must be ≤256.
- TIME_WIDTH, 16, timestamp width (fixed 16 by packet format).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  block enable
- s_axis_input_tdata  in  48  {timestamp[47:32], ch[31:24], y[23:16], x[15:8], valid[7:0]}
- s_axis_input_tvalid  in  1  input beat valid
- s_axis_input_tready  out  1  input ready (registered)
- s_axis_input_tlast  in  1  end of input frame
- m_axis_output_tdata  out  48  same packing; valid byte = 8'h01
- m_axis_output_tvalid  out  1  output valid
- m_axis_output_tready  in  1  downstream ready
- m_axis_output_tlast  out  1  end of output frame
- input_spike_count  out  32  accepted, in-range spikes
- output_spike_count  out  32  completed output handshakes
- dropped_spike_count  out  32  accepted but discarded beats
- busy  out  1  state≠IDLE or m_axis_output_tvalid

Behaviour:
- Reset: all outputs 0, including tready, tdata, tvalid, tlast, counters and busy. FSM goes to IDLE.
- First cycle after reset with enable=1: tready=1.
- States:
  - IDLE: tready=enable. A beat is accepted when tvalid&&tready.
    - Drop the beat if valid byte==0, x≥INPUT_WIDTH, y≥INPUT_HEIGHT or ch≥INPUT_CHANNELS. On drop: dropped_spike_count+1, stay IDLE, tready stays 1.
    - Otherwise latch ts/ch/y/x/tlast, set dy=dx=0, input_spike_count+1, go to EXPAND, tready=0.
  - EXPAND: the output register loads when (!m_tvalid || m_tready) && enable.
    - Load value: tdata={ts, ch, y*SCALE+dy, x*SCALE+dx, 8'h01}, tvalid=1.
    - tlast=1 only on the final replicate (dy=dx=SCALE-1) when the latched tlast=1.
    - Order: dx increments first, then dy (raster).
    - After the final replicate loads: return to IDLE and set tready=1 on the same edge.
- Address arithmetic is 8-bit and never overflows, given the parameter constraint.
- Latency: first replicate tvalid appears 1 cycle after the accept edge.
- Throughput with m_tready held high: one output per cycle; at most one input per SCALE²+1 cycles.
- AXI rules:
  - Once tvalid=1, tdata and tlast hold until the tready handshake.
  - tvalid drops the cycle after a handshake if no new load occurs.
  - A handshake and a new load in the same cycle is allowed; tvalid stays 1.
- output_spike_count increments on each m_tvalid&&m_tready.
- enable=0:
  - No accepts; tready goes 0 next edge.
  - EXPAND pauses at the current (dy, dx).
  - A pending output still completes its handshake.
  - Counters freeze except output_spike_count on that handshake.
- Reset mid-EXPAND: the remaining replicates are discarded and the pending output is cleared.
- Counters wrap modulo 2^32.

Optional Feature:
- Macro SNN_UPSAMPLE_TS_STAGGER_EN.
- Defined: adds input port ts_stagger [7:0]. Replicate k=dy*SCALE+dx carries timestamp ts + k*ts_stagger, modulo 2^16. ts_stagger is sampled at input accept.
- Undefined: the port is absent and every replicate carries the input timestamp unchanged.

Test Plan:
- SCALE=2; spike ch=3, y=2, x=5, ts=0x0100; m_tready=1 → four outputs on consecutive cycles at (y,x)=(4,10),(4,11),(5,10),(5,11). Each has ts 0x0100, ch 3, valid 0x01. tready low 4 cycles, then high; counts in=1, out=4.
- Same spike, m_tready low 3 cycles while replicate (4,11) is presented → tdata stable throughout; all 4 outputs delivered in order; out=4.
- Beats with x=14, then ch=40, then valid byte=0x00 → no outputs; dropped_spike_count=3; tready stays 1; in=0.
- Two back-to-back spikes, second with tlast=1 → 8 outputs; only the 8th has tlast=1; second beat accepted 5 cycles after the first.
- Reset asserted after 2 replicates → next cycle tvalid=0, all counters 0, busy=0; no remaining replicates emitted.
- Macro on, ts=0xFFFE, ts_stagger=3 → timestamps 0xFFFE, 0x0001, 0x0004, 0x0007.

Source files
------------

// File: rtl/snn_upsample2d.sv
// Spike-domain nearest-neighbour 2D upsampler: one input spike becomes SCALE x SCALE output spikes.
// Optional SNN_UPSAMPLE_TS_STAGGER_EN adds ts_stagger, which offsets each replicate's timestamp.
module snn_upsample2d #(
    parameter int INPUT_WIDTH    = 14,
    parameter int INPUT_HEIGHT   = 14,
    parameter int INPUT_CHANNELS = 32,
    parameter int SCALE          = 2,
    parameter int TIME_WIDTH     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
`ifdef SNN_UPSAMPLE_TS_STAGGER_EN
    input  logic [7:0]  ts_stagger,
`endif
    input  logic [47:0] s_axis_input_tdata,
    input  logic        s_axis_input_tvalid,
    output logic        s_axis_input_tready,
    input  logic        s_axis_input_tlast,
    output logic [47:0] m_axis_output_tdata,
    output logic        m_axis_output_tvalid,
    input  logic        m_axis_output_tready,
    output logic        m_axis_output_tlast,
    output logic [31:0] input_spike_count,
    output logic [31:0] output_spike_count,
    output logic [31:0] dropped_spike_count,
    output logic        busy
);

    localparam logic [7:0] SCALE_B  = 8'(SCALE);
    localparam logic [1:0] LAST_IDX = 2'(SCALE - 1);
    localparam logic [8:0] W_LIM    = 9'(INPUT_WIDTH);
    localparam logic [8:0] H_LIM    = 9'(INPUT_HEIGHT);
    localparam logic [8:0] C_LIM    = 9'(INPUT_CHANNELS);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t                  state_q;
    logic                    tready_q;
    logic [47:0]             tdata_q;
    logic                    tvalid_q;
    logic                    tlast_q;
    logic [31:0]             in_cnt_q;
    logic [31:0]             out_cnt_q;
    logic [31:0]             drop_cnt_q;
    logic [TIME_WIDTH-1:0]   ts_q;
    logic [7:0]              ch_q;
    logic [7:0]              y_q;
    logic [7:0]              x_q;
    logic                    last_q;
    logic [1:0]              dy_q;
    logic [1:0]              dx_q;
`ifdef SNN_UPSAMPLE_TS_STAGGER_EN
    logic [TIME_WIDTH-1:0]   stagger_q;
`endif

    logic [TIME_WIDTH-1:0]   in_ts;
    logic [7:0]              in_ch;
    logic [7:0]              in_y;
    logic [7:0]              in_x;
    logic [7:0]              in_valid;
    logic                    accept;
    logic                    in_range;
    logic                    load;
    logic                    final_rep;
    logic                    out_hs;
    logic [47:0]             tdata_d;
    logic                    tlast_d;

    assign {in_ts, in_ch, in_y, in_x, in_valid} = s_axis_input_tdata;

    assign accept    = (state_q == IDLE) && tready_q && s_axis_input_tvalid;
    assign in_range  = (in_valid != 8'd0) && ({1'b0, in_x} < W_LIM) &&
                       ({1'b0, in_y} < H_LIM) && ({1'b0, in_ch} < C_LIM);
    // The output register may refill in the same cycle its current beat is taken.
    assign load      = (state_q == EXPAND) && (!tvalid_q || m_axis_output_tready) && enable;
    assign out_hs    = tvalid_q && m_axis_output_tready;
    assign final_rep = (dy_q == LAST_IDX) && (dx_q == LAST_IDX);

    always_comb begin
        tdata_d = {ts_q, ch_q, y_q * SCALE_B + {6'd0, dy_q}, x_q * SCALE_B + {6'd0, dx_q}, 8'h01};
        tlast_d = last_q && final_rep;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tready_q   <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ts_q       <= '0;
            ch_q       <= '0;
            y_q        <= '0;
            x_q        <= '0;
            last_q     <= 1'b0;
            dy_q       <= '0;
            dx_q       <= '0;
`ifdef SNN_UPSAMPLE_TS_STAGGER_EN
            stagger_q  <= '0;
`endif
        end else begin
            if (out_hs) begin
                out_cnt_q <= out_cnt_q + 32'd1;
            end
            if (load) begin
                tdata_q  <= tdata_d;
                tvalid_q <= 1'b1;
                tlast_q  <= tlast_d;
            end else if (out_hs) begin
                tvalid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    tready_q <= enable;
                    if (accept) begin
                        if (in_range) begin
                            ts_q     <= in_ts;
                            ch_q     <= in_ch;
                            y_q      <= in_y;
                            x_q      <= in_x;
                            last_q   <= s_axis_input_tlast;
                            dy_q     <= '0;
                            dx_q     <= '0;
`ifdef SNN_UPSAMPLE_TS_STAGGER_EN
                            stagger_q <= TIME_WIDTH'(ts_stagger);
`endif
                            in_cnt_q <= in_cnt_q + 32'd1;
                            tready_q <= 1'b0;
                            state_q  <= EXPAND;
                        end else begin
                            drop_cnt_q <= drop_cnt_q + 32'd1;
                        end
                    end
                end
                EXPAND: begin
                    if (load) begin
`ifdef SNN_UPSAMPLE_TS_STAGGER_EN
                        ts_q <= ts_q + stagger_q;
`endif
                        if (final_rep) begin
                            dy_q     <= '0;
                            dx_q     <= '0;
                            tready_q <= 1'b1;
                            state_q  <= IDLE;
                        end else if (dx_q == LAST_IDX) begin
                            dx_q <= '0;
                            dy_q <= dy_q + 2'd1;
                        end else begin
                            dx_q <= dx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_axis_input_tready  = tready_q;
    assign m_axis_output_tdata  = tdata_q;
    assign m_axis_output_tvalid = tvalid_q;
    assign m_axis_output_tlast  = tlast_q;
    assign input_spike_count    = in_cnt_q;
    assign output_spike_count   = out_cnt_q;
    assign dropped_spike_count  = drop_cnt_q;
    assign busy                 = (state_q != IDLE) || tvalid_q;

endmodule

// File: tb/tb_snn_upsample2d.sv
// Bench for snn_upsample2d: queue-based reference model, per-cycle compare process, directed + random stimulus.
module tb_snn_upsample2d;

    localparam int S  = 2;
    localparam int IW = 14;
    localparam int IH = 14;
    localparam int IC = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [47:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [47:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [31:0] in_cnt, out_cnt, drop_cnt;
    logic        busy;
`ifdef SNN_UPSAMPLE_TS_STAGGER_EN
    logic [7:0]  ts_stagger = 8'd0;
`endif

    snn_upsample2d #(
        .INPUT_WIDTH(IW), .INPUT_HEIGHT(IH), .INPUT_CHANNELS(IC), .SCALE(S), .TIME_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
`ifdef SNN_UPSAMPLE_TS_STAGGER_EN
        .ts_stagger(ts_stagger),
`endif
        .s_axis_input_tdata(s_tdata),
        .s_axis_input_tvalid(s_tvalid),
        .s_axis_input_tready(s_tready),
        .s_axis_input_tlast(s_tlast),
        .m_axis_output_tdata(m_tdata),
        .m_axis_output_tvalid(m_tvalid),
        .m_axis_output_tready(m_tready),
        .m_axis_output_tlast(m_tlast),
        .input_spike_count(in_cnt),
        .output_spike_count(out_cnt),
        .dropped_spike_count(drop_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    bit          rand_rdy = 1'b0;
    logic [48:0] exp_q [$];
    int unsigned m_in = 0, m_out = 0, m_drop = 0, m_lasts = 0;
    bit          prev_stall = 1'b0;
    logic [47:0] prev_data;
    logic        prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: every in-range accepted beat expands into SCALE*SCALE raster-ordered spikes.
    task automatic model_accept(input logic [47:0] d, input logic last, input logic [7:0] stg);
        logic [15:0] ts;
        logic [7:0]  ch, y, x, v;
        {ts, ch, y, x, v} = d;
        if (v == 0 || x >= IW || y >= IH || ch >= IC) begin
            m_drop++;
        end else begin
            m_in++;
            for (int k = 0; k < S * S; k++) begin
                logic [15:0] rts;
                logic [7:0]  ry, rx;
                rts = 16'(ts + k * stg);
                ry  = 8'(y * S + k / S);
                rx  = 8'(x * S + k % S);
                exp_q.push_back({last && (k == S * S - 1), rts, ch, ry, rx, 8'h01});
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_in = 0; m_out = 0; m_drop = 0;
            prev_stall = 1'b0;
        end else begin
            check("in_count", {32'd0, in_cnt}, {32'd0, m_in});
            check("out_count", {32'd0, out_cnt}, {32'd0, m_out});
            check("drop_count", {32'd0, drop_cnt}, {32'd0, m_drop});
            check("busy", {63'd0, busy}, {63'd0, exp_q.size() > 0});
            if (prev_stall) begin
                check("hold_tvalid", {63'd0, m_tvalid}, 64'd1);
                check("hold_tdata", {16'd0, m_tdata}, {16'd0, prev_data});
                check("hold_tlast", {63'd0, m_tlast}, {63'd0, prev_last});
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {16'd0, m_tdata}, 64'd0 - 64'd1);
                end else begin
                    logic [48:0] e;
                    e = exp_q.pop_front();
                    check("out_tdata", {16'd0, m_tdata}, {16'd0, e[47:0]});
                    check("out_tlast", {63'd0, m_tlast}, {63'd0, e[48]});
                end
                m_out++;
                if (m_tlast) m_lasts++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (s_tvalid && s_tready) begin
`ifdef SNN_UPSAMPLE_TS_STAGGER_EN
                model_accept(s_tdata, s_tlast, ts_stagger);
`else
                model_accept(s_tdata, s_tlast, 8'd0);
`endif
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) m_tready = ($urandom_range(0, 9) < 7);
    end

    // All stimulus tasks are entered and left 1 time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        check("rst_tdata", {16'd0, m_tdata}, 64'd0);
        check("rst_tlast", {63'd0, m_tlast}, 64'd0);
        check("rst_tready", {63'd0, s_tready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_counts", {in_cnt, out_cnt | drop_cnt}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_tready", {63'd0, s_tready}, {63'd0, enable});
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] ts, input logic [7:0] ch, input logic [7:0] y,
                             input logic [7:0] x, input logic [7:0] v, input logic last,
                             output int acc);
        bit got;
        s_tdata  = {ts, ch, y, x, v};
        s_tlast  = last;
        s_tvalid = 1'b1;
        got = 1'b0;
        acc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = s_tready;
            @(posedge clk);
            #1;
            acc = cyc;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (!got) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = !busy && (exp_q.size() == 0);
            @(posedge clk);
            #1;
        end
        if (!done) check("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int          a0, a1;
        int unsigned l0;
        logic [47:0] lit [4];
        lit[0] = 48'h0100_0304_0A01;
        lit[1] = 48'h0100_0304_0B01;
        lit[2] = 48'h0100_0305_0A01;
        lit[3] = 48'h0100_0305_0B01;

        @(posedge clk);
        #1;
        do_reset();

        // Single spike, free-running sink: four raster replicates on consecutive cycles.
        send_beat(16'h0100, 8'd3, 8'd2, 8'd5, 8'h01, 1'b0, a0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) check("t1_latency", {63'd0, m_tvalid}, 64'd0);
            if (i >= 1 && i <= 4) begin
                check("t1_tvalid", {63'd0, m_tvalid}, 64'd1);
                check("t1_tdata", {16'd0, m_tdata}, {16'd0, lit[i-1]});
            end
            check("t1_tready", {63'd0, s_tready}, {63'd0, i >= 4});
            if (i == 5) begin
                check("t1_idle", {63'd0, m_tvalid}, 64'd0);
                check("t1_counts", {in_cnt, out_cnt}, {32'd1, 32'd4});
            end
        end
        @(posedge clk);
        #1;

        // Backpressure while (4,11) is presented.
        do_reset();
        send_beat(16'h0100, 8'd3, 8'd2, 8'd5, 8'h01, 1'b0, a0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_stall_data", {16'd0, m_tdata}, {16'd0, lit[1]});
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        wait_idle();
        check("t2_out_count", {32'd0, out_cnt}, 64'd4);

        // Out-of-range and invalid beats are discarded.
        do_reset();
        send_beat(16'h0010, 8'd1, 8'd1, 8'd14, 8'h01, 1'b0, a0);
        @(negedge clk); check("t3_tready_a", {63'd0, s_tready}, 64'd1); @(posedge clk); #1;
        send_beat(16'h0010, 8'd40, 8'd1, 8'd1, 8'h01, 1'b0, a0);
        @(negedge clk); check("t3_tready_b", {63'd0, s_tready}, 64'd1); @(posedge clk); #1;
        send_beat(16'h0010, 8'd1, 8'd1, 8'd1, 8'h00, 1'b0, a0);
        @(negedge clk);
        check("t3_tready_c", {63'd0, s_tready}, 64'd1);
        check("t3_counts", {in_cnt, drop_cnt}, {32'd0, 32'd3});
        check("t3_no_out", {63'd0, m_tvalid}, 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back spikes; the second closes the frame.
        do_reset();
        l0 = m_lasts;
        send_beat(16'h0200, 8'd7, 8'd0, 8'd0, 8'h01, 1'b0, a0);
        send_beat(16'h0201, 8'd8, 8'd13, 8'd13, 8'h01, 1'b1, a1);
        check("t4_accept_gap", 64'(a1 - a0), 64'd5);
        wait_idle();
        check("t4_out_count", {32'd0, out_cnt}, 64'd8);
        check("t4_tlast_count", 64'(m_lasts - l0), 64'd1);

        // Reset after two replicates have been delivered.
        do_reset();
        send_beat(16'h0100, 8'd3, 8'd2, 8'd5, 8'h01, 1'b0, a0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t5_out_before_rst", {32'd0, out_cnt}, 64'd2);
        do_reset();
        repeat (6) begin
            @(negedge clk);
            check("t5_no_leftover", {63'd0, m_tvalid}, 64'd0);
            @(posedge clk);
            #1;
        end

`ifdef SNN_UPSAMPLE_TS_STAGGER_EN
        begin
            logic [15:0] tsl [4];
            tsl[0] = 16'hFFFE; tsl[1] = 16'h0001; tsl[2] = 16'h0004; tsl[3] = 16'h0007;
            do_reset();
            ts_stagger = 8'd3;
            send_beat(16'hFFFE, 8'd3, 8'd2, 8'd5, 8'h01, 1'b0, a0);
            ts_stagger = 8'd0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (i >= 1) check("t6_stagger_ts", {48'd0, m_tdata[47:32]}, {48'd0, tsl[i-1]});
            end
            @(posedge clk);
            #1;
        end
`endif

        // Randomised traffic with sink backpressure and enable pauses.
        do_reset();
        rand_rdy = 1'b1;
        for (int n = 0; n < 150; n++) begin
            logic [7:0] vb;
            vb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
`ifdef SNN_UPSAMPLE_TS_STAGGER_EN
            ts_stagger = 8'($urandom_range(0, 255));
`endif
            send_beat(16'($urandom), 8'($urandom_range(0, 40)), 8'($urandom_range(0, 15)),
                      8'($urandom_range(0, 15)), vb, 1'($urandom_range(0, 1)), a0);
            if ($urandom_range(0, 5) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk);
                    #1;
                end
                enable = 1'b1;
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        m_tready = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
